// File: rtl/decoder_sel_scanner.sv
// Scan controller that walks the decoder select from 0 to last_sel with a programmable dwell.
// Optional feature macro: SCAN_SKIP_EN adds skip_mask to jump over masked addresses.
module decoder_sel_scanner #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SEL_W-1:0]   last_sel,
`ifdef SCAN_SKIP_EN
    input  logic [2**SEL_W-1:0] skip_mask,
`endif
    output logic [SEL_W-1:0]   s,
    output logic               s_valid,
    output logic               step,
    output logic               busy,
    output logic               done
);

    localparam int NADDR = 2**SEL_W;
    localparam int AW    = SEL_W + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [SEL_W-1:0]   r_s;
    logic               r_s_valid;
    logic               r_step;
    logic               r_busy;
    logic               r_done;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell;
    logic [SEL_W-1:0]   r_last;
    logic               r_cont;

    logic [NADDR-1:0]   w_mask_in;
    logic [NADDR-1:0]   w_mask_run;
    logic [AW-1:0]      w_first;
    logic [AW-1:0]      w_next;
    logic [AW-1:0]      w_wrap;

`ifdef SCAN_SKIP_EN
    logic [NADDR-1:0]   r_mask;
    assign w_mask_in  = skip_mask;
    assign w_mask_run = r_mask;
`else
    assign w_mask_in  = '0;
    assign w_mask_run = '0;
`endif

    // Lowest unmasked address in [base, last]; MSB of the result flags a hit.
    function automatic logic [AW-1:0] f_seek(
        input logic [NADDR-1:0] mask,
        input logic [AW-1:0]    base,
        input logic [SEL_W-1:0] last
    );
        logic [AW-1:0] res;
        res = '0;
        for (int i = NADDR - 1; i >= 0; i--) begin
            if (!mask[i] && (AW'(i) >= base) && (SEL_W'(i) <= last))
                res = {1'b1, SEL_W'(i)};
        end
        return res;
    endfunction

    assign w_first = f_seek(w_mask_in, '0, last_sel);
    assign w_next  = f_seek(w_mask_run, {1'b0, r_s} + AW'(1), r_last);
    assign w_wrap  = f_seek(w_mask_run, '0, r_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_s       <= '0;
            r_s_valid <= 1'b0;
            r_step    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_dwell   <= '0;
            r_last    <= '0;
            r_cont    <= 1'b0;
`ifdef SCAN_SKIP_EN
            r_mask    <= '0;
`endif
        end else begin
            r_step <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start && !stop && w_first[SEL_W]) begin
                        r_dwell   <= dwell;
                        r_last    <= last_sel;
                        r_cont    <= mode_cont;
`ifdef SCAN_SKIP_EN
                        r_mask    <= skip_mask;
`endif
                        r_state   <= S_RUN;
                        r_s       <= w_first[SEL_W-1:0];
                        r_s_valid <= 1'b1;
                        r_busy    <= 1'b1;
                        r_step    <= 1'b1;
                        r_cnt     <= dwell;
                    end
                end
                S_RUN: begin
                    // Abort wins over hold expiry and never produces done.
                    if (stop) begin
                        r_state   <= S_IDLE;
                        r_s       <= '0;
                        r_s_valid <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end else if (w_next[SEL_W]) begin
                        r_s    <= w_next[SEL_W-1:0];
                        r_step <= 1'b1;
                        r_cnt  <= r_dwell;
                    end else if (r_cont) begin
                        r_s    <= w_wrap[SEL_W-1:0];
                        r_step <= 1'b1;
                        r_cnt  <= r_dwell;
                    end else begin
                        r_state   <= S_IDLE;
                        r_s       <= '0;
                        r_s_valid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_s       <= '0;
                    r_s_valid <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign s       = r_s;
    assign s_valid = r_s_valid;
    assign step    = r_step;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_decoder_sel_scanner.sv
// Scoreboard bench for decoder_sel_scanner; expected traces are built from scan parameters.
// Define SCAN_SKIP_EN to also exercise the skip-mask scenarios.
module tb_decoder_sel_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode_cont = 1'b0;
    logic [7:0] dwell = '0;
    logic [2:0] last_sel = '0;
`ifdef SCAN_SKIP_EN
    logic [7:0] skip_mask = '0;
`endif
    logic [2:0] s;
    logic       s_valid;
    logic       step;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_fail = 0;
    logic [6:0] sb[$];

    decoder_sel_scanner #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .mode_cont(mode_cont),
        .dwell(dwell),
        .last_sel(last_sel),
`ifdef SCAN_SKIP_EN
        .skip_mask(skip_mask),
`endif
        .s(s),
        .s_valid(s_valid),
        .step(step),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] mk(input int a, input bit v, input bit st,
                                      input bit b, input bit d);
        logic [2:0] a3;
        a3 = a[2:0];
        return {a3, v, st, b, d};
    endfunction

    task automatic push_hold(input int a, input int dw);
        sb.push_back(mk(a, 1, 1, 1, 0));
        repeat (dw) sb.push_back(mk(a, 1, 0, 1, 0));
    endtask

    task automatic push_idle();
        sb.push_back(mk(0, 0, 0, 0, 0));
    endtask

    task automatic push_end();
        sb.push_back(mk(0, 0, 0, 0, 1));
        push_idle();
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (sb.size() == 0)
            chk({tag, "_sb_empty"}, 0, 1);
        else
            chk(tag, {s, s_valid, step, busy, done}, sb.pop_front());
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) tick(tag);
    endtask

    task automatic go(input int dw, input int last, input bit cont);
        dwell = 8'(dw);
        last_sel = 3'(last);
        mode_cont = cont;
        start = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        push_idle();
        push_idle();
        drain("reset");
        rst = 1'b0;

        // single shot, new address every cycle
        push_hold(0, 0);
        go(0, 7, 0);
        tick("t2_first");
        start = 1'b0;
        for (int a = 1; a < 8; a++) push_hold(a, 0);
        push_end();
        drain("t2_scan");

        // continuous scan with dwell, config changed mid-run, then stop at expiry
        push_hold(0, 2);
        go(2, 3, 1);
        tick("t3_first");
        start = 1'b0;
        dwell = 8'd0;
        last_sel = 3'd7;
        mode_cont = 1'b0;
        for (int a = 1; a < 4; a++) push_hold(a, 2);
        push_hold(0, 2);
        drain("t3_scan");
        stop = 1'b1;
        push_idle();
        tick("t3_stop");
        stop = 1'b0;
        push_idle();
        push_idle();
        drain("t3_nodone");

        // start with stop in idle is ignored
        go(0, 5, 0);
        stop = 1'b1;
        push_idle();
        tick("t4_startstop");
        stop = 1'b0;
        start = 1'b0;
        push_idle();
        tick("t4_idle");

        // restart attempt mid-run is ignored
        push_hold(0, 0);
        go(0, 5, 0);
        tick("t4_first");
        start = 1'b0;
        push_hold(1, 0);
        tick("t4_s1");
        go(0, 1, 0);
        for (int a = 2; a < 6; a++) push_hold(a, 0);
        push_end();
        tick("t4_restart");
        start = 1'b0;
        drain("t4_scan");

        // single address, long dwell
        push_hold(0, 4);
        go(4, 0, 0);
        tick("t5_first");
        start = 1'b0;
        push_end();
        drain("t5_scan");

        // single address repeated in continuous mode
        push_hold(0, 0);
        go(0, 0, 1);
        tick("t5c_first");
        start = 1'b0;
        push_hold(0, 0);
        push_hold(0, 0);
        drain("t5c_repeat");
        stop = 1'b1;
        push_idle();
        tick("t5c_stop");
        stop = 1'b0;

        // async reset mid-scan
        push_hold(0, 3);
        go(3, 7, 1);
        tick("t1_first");
        start = 1'b0;
        push_hold(1, 0);
        sb.push_back(mk(1, 1, 0, 1, 0));
        drain("t1_run");
        #2;
        rst = 1'b1;
        #1;
        push_idle();
        chk("t1_async", {s, s_valid, step, busy, done}, sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        push_idle();
        tick("t1_after");

`ifdef SCAN_SKIP_EN
        skip_mask = 8'b1010_0101;
        push_hold(1, 0);
        go(0, 7, 0);
        tick("t6_first");
        start = 1'b0;
        push_hold(3, 0);
        push_hold(4, 0);
        push_hold(6, 0);
        push_end();
        drain("t6_skip");

        skip_mask = 8'h0F;
        go(0, 3, 0);
        push_idle();
        tick("t6_allmask");
        start = 1'b0;
        push_idle();
        tick("t6_idle");
        skip_mask = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
